// File: rtl/fib_range_scanner.sv
// ---------------------------------------------------------------------------
// fib_range_scanner
//
// Sequencer placed in front of an isFibonacci analyzer. It walks an inclusive
// range of numbers. For each number it presents the value on `number` and
// raises `go_i`. It waits for the analyzer to report a terminal state and
// records the result. It then drops `go_i` so the analyzer can return to its
// initial state before the next number is issued. When the range is
// exhausted it pulses `done`, and the hit count and the last hit remain
// readable until the next accepted `start`.
//
// Optional build macro:
//   SCAN_WATCHDOG_EN - adds a per-item watchdog. An item that has not
//                      finished after TIMEOUT WAIT cycles is scored as
//                      result 0 and sets the sticky `timeout_flag`.
//                      Without the macro, WAIT waits indefinitely and
//                      `timeout_flag` is tied to 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   single-cycle scan request, honoured only when idle
//   range_lo     in   first number (inclusive), captured with start
//   range_hi     in   last number (inclusive), captured with start
//   ana_result   in   analyzer result bit
//   ana_state    in   analyzer state code (terminal codes DONE_A / DONE_B)
//   number       out  number presented to the analyzer (registered)
//   go_i         out  analyzer go (registered)
//   busy         out  high whenever the scanner is not idle
//   done         out  one-cycle pulse at the end of a scan
//   hit_count    out  saturating count of results equal to 1
//   last_hit     out  most recent number whose result was 1 (0 if none)
//   timeout_flag out  sticky: some item of the scan hit the watchdog
// ---------------------------------------------------------------------------
module fib_range_scanner #(
  parameter int         WIDTH       = 32,
  parameter int         CNT_W       = 16,
  parameter logic [3:0] DONE_A      = 4'd7,
  parameter logic [3:0] DONE_B      = 4'd8,
  parameter int         RELEASE_CYC = 2
`ifdef SCAN_WATCHDOG_EN
  ,
  parameter int         TIMEOUT     = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] range_lo,
  input  logic [WIDTH-1:0] range_hi,
  input  logic             ana_result,
  input  logic [3:0]       ana_state,
  output logic [WIDTH-1:0] number,
  output logic             go_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic [WIDTH-1:0] last_hit,
  output logic             timeout_flag
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  // The RELEASE counter saturates at RELEASE_CYC-1. The exit edge is the
  // RELEASE_CYC-th edge spent in the state.
  localparam int               REL_W    = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYC - 1);

  logic [2:0]       state_r;
  logic [WIDTH-1:0] cur_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] number_r;
  logic             go_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] hit_count_r;
  logic [WIDTH-1:0] last_hit_r;
  logic [REL_W-1:0] rel_cnt_r;

  logic ana_done_s;
  logic rel_ok_s;
  logic start_accept_s;
  logic wd_expired_s;

  assign ana_done_s     = (ana_state == DONE_A) || (ana_state == DONE_B);
  assign rel_ok_s       = (rel_cnt_r == REL_LAST);
  assign start_accept_s = (state_r == ST_IDLE) && start;

`ifdef SCAN_WATCHDOG_EN
  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wdog_r;
  logic            timeout_r;

  // Counter value is (WAIT cycles - 1), so the last allowed cycle is TIMEOUT-1.
  assign wd_expired_s = (wdog_r == WD_LAST);
  assign timeout_flag = timeout_r;

  // Watchdog counter plus the sticky timeout flag. A real terminal state
  // seen on the same edge as expiry takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r == ST_ISSUE) begin
        wdog_r <= '0;
      end else if ((state_r == ST_WAIT) && !wd_expired_s) begin
        wdog_r <= wdog_r + WD_W'(1);
      end else begin
        wdog_r <= wdog_r;
      end

      if (start_accept_s) begin
        timeout_r <= 1'b0;
      end else if ((state_r == ST_WAIT) && !ana_done_s && wd_expired_s) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end
`else
  assign wd_expired_s = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign number    = number_r;
  assign go_i      = go_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign hit_count = hit_count_r;
  assign last_hit  = last_hit_r;

  // Main scan sequencer: walks cur_r from range_lo up to the captured range_hi.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cur_r       <= '0;
      hi_r        <= '0;
      number_r    <= '0;
      go_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hit_count_r <= '0;
      last_hit_r  <= '0;
      rel_cnt_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            hit_count_r <= '0;
            last_hit_r  <= '0;
            hi_r        <= range_hi;
            busy_r      <= 1'b1;
            if (range_lo > range_hi) begin
              state_r <= ST_FINISH;
            end else begin
              cur_r   <= range_lo;
              state_r <= ST_ISSUE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          number_r <= cur_r;
          go_r     <= 1'b1;
          state_r  <= ST_WAIT;
        end

        ST_WAIT: begin
          if (ana_done_s) begin
            if (ana_result) begin
              if (hit_count_r != {CNT_W{1'b1}}) begin
                hit_count_r <= hit_count_r + CNT_W'(1);
              end else begin
                hit_count_r <= hit_count_r;
              end
              last_hit_r <= cur_r;
            end else begin
              last_hit_r <= last_hit_r;
            end
            go_r      <= 1'b0;
            rel_cnt_r <= '0;
            state_r   <= ST_RELEASE;
          end else if (wd_expired_s) begin
            go_r      <= 1'b0;
            rel_cnt_r <= '0;
            state_r   <= ST_RELEASE;
          end else begin
            state_r <= ST_WAIT;
          end
        end

        ST_RELEASE: begin
          // Comparing against the upper bound before incrementing means a
          // range ending at all-ones never wraps back to zero.
          if (rel_ok_s && !ana_done_s) begin
            if (cur_r == hi_r) begin
              state_r <= ST_FINISH;
            end else begin
              cur_r   <= cur_r + WIDTH'(1);
              state_r <= ST_ISSUE;
            end
          end else begin
            if (rel_cnt_r != REL_LAST) begin
              rel_cnt_r <= rel_cnt_r + REL_W'(1);
            end else begin
              rel_cnt_r <= rel_cnt_r;
            end
            state_r <= ST_RELEASE;
          end
        end

        ST_FINISH: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
          go_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_range_scanner.sv
module tb_fib_range_scanner;

  localparam int CNT_W = 3;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] range_lo;
  logic [31:0] range_hi;
  logic        ana_result;
  logic [3:0]  ana_state;
  logic [31:0] number;
  logic        go_i;
  logic        busy;
  logic        done;
  logic [CNT_W-1:0] hit_count;
  logic [31:0] last_hit;
  logic        timeout_flag;
  logic        stuck;

  always #5 clk = ~clk;

  fib_range_scanner #(
    .WIDTH(32), .CNT_W(CNT_W), .DONE_A(4'd7), .DONE_B(4'd8), .RELEASE_CYC(2)
`ifdef SCAN_WATCHDOG_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .range_lo(range_lo), .range_hi(range_hi),
    .ana_result(ana_result), .ana_state(ana_state), .number(number), .go_i(go_i),
    .busy(busy), .done(done), .hit_count(hit_count), .last_hit(last_hit),
    .timeout_flag(timeout_flag)
  );

  typedef struct {
    logic [CNT_W-1:0] hits;
    logic [31:0]      last;
    logic             to;
    int               items;
  } scan_t;

  scan_t       exp_scan_q[$];
  logic [31:0] exp_num_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic is_fib(input logic [31:0] v);
    longint unsigned a = 0;
    longint unsigned b = 1;
    longint unsigned t;
    while (a < 64'(v)) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a == 64'(v);
  endfunction

  // Stub analyzer: terminal state LAT cycles after go, cleared when go drops.
  logic [31:0] lat_cnt;
  always @(posedge clk) begin
    if (reset || !go_i) begin
      ana_state  <= 4'd0;
      ana_result <= 1'b0;
      lat_cnt    <= 32'd0;
    end else if (!stuck && ana_state == 4'd0) begin
      if (lat_cnt == 32'(LAT - 1)) begin
        ana_state  <= number[0] ? 4'd8 : 4'd7;
        ana_result <= is_fib(number);
      end else begin
        lat_cnt <= lat_cnt + 32'd1;
      end
    end
  end

  // Monitor: checks every issued item and every completed scan against the queues.
  initial begin : monitor
    int gap, items, hi_len;
    logic go_prev;
    logic [31:0] cur_num;
    scan_t s;
    gap = 100; items = 0; hi_len = 0; go_prev = 1'b0; cur_num = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        gap = 100; items = 0; hi_len = 0; go_prev = 1'b0;
      end else begin
        if (go_i) begin
          if (!go_prev) begin
            check("go_low_gap_ok", 64'(gap >= 2), 64'd1);
            if (exp_num_q.size() == 0) begin
              check("go_without_expected_item", 64'd1, 64'd0);
            end else begin
              cur_num = exp_num_q.pop_front();
              check("number", 64'(number), 64'(cur_num));
            end
            items++;
            hi_len = 0;
          end
          hi_len++;
        end else begin
          if (go_prev) begin
            check("number_stable", 64'(number), 64'(cur_num));
`ifdef SCAN_WATCHDOG_EN
            if (stuck) check("timeout_go_cycles", 64'(hi_len), 64'd16);
`endif
            gap = 0;
          end
          gap++;
        end
        if (done) begin
          if (exp_scan_q.size() == 0) begin
            check("done_without_expected_scan", 64'd1, 64'd0);
          end else begin
            s = exp_scan_q.pop_front();
            check("hit_count", 64'(hit_count), 64'(s.hits));
            check("last_hit", 64'(last_hit), 64'(s.last));
            check("timeout_flag", 64'(timeout_flag), 64'(s.to));
            check("items", 64'(items), 64'(s.items));
            check("busy_at_done", 64'(busy), 64'd0);
          end
          items = 0;
        end
        go_prev = go_i;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [31:0] lo, input logic [31:0] hi,
                          input logic [CNT_W-1:0] h, input logic [31:0] l, input logic to);
    scan_t s;
    for (longint unsigned v = 64'(lo); v <= 64'(hi); v++) exp_num_q.push_back(v[31:0]);
    s.hits  = h;
    s.last  = l;
    s.to    = to;
    s.items = (lo > hi) ? 0 : int'(64'(hi) - 64'(lo) + 64'd1);
    exp_scan_q.push_back(s);
    range_lo = lo;
    range_hi = hi;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("done_timeout", 64'd0, 64'd1);
    tick();
    check("done_single_pulse", 64'(done), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_go"}, 64'(go_i), 64'd0);
    check({tag, "_number"}, 64'(number), 64'd0);
    check({tag, "_hits"}, 64'(hit_count), 64'd0);
    check({tag, "_last"}, 64'(last_hit), 64'd0);
    check({tag, "_timeout"}, 64'(timeout_flag), 64'd0);
  endtask

  initial begin : driver
    bit seen;
    reset = 1'b1; start = 1'b0; range_lo = 32'd0; range_hi = 32'd0; stuck = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Single Fibonacci item, with first-item latency.
    run_scan(32'd89, 32'd89, 3'd1, 32'd89, 1'b0);
    check("issue_busy", 64'(busy), 64'd1);
    check("issue_go_low", 64'(go_i), 64'd0);
    tick();
    check("first_go", 64'(go_i), 64'd1);
    check("first_number", 64'(number), 64'd89);
    wait_done(200);

    // 0..13: seven hits.
    run_scan(32'd0, 32'd13, 3'd7, 32'd13, 1'b0);
    wait_done(1000);

    // Empty range: done two cycles after start, no items.
    run_scan(32'd20, 32'd10, 3'd0, 32'd0, 1'b0);
    check("empty_done_early", 64'(done), 64'd0);
    check("empty_busy", 64'(busy), 64'd1);
    tick();
    check("empty_done", 64'(done), 64'd1);
    check("empty_busy_after", 64'(busy), 64'd0);
    tick();
    check("empty_done_pulse", 64'(done), 64'd0);

    // Top of range: two items, no wrap.
    run_scan(32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'd0, 32'd0, 1'b0);
    wait_done(200);
    repeat (5) tick();
    check("top_no_wrap_number", 64'(number), 64'hFFFF_FFFF);
    check("top_idle_go", 64'(go_i), 64'd0);

    // 0..34 has nine hits; a 3-bit counter saturates at 7.
    run_scan(32'd0, 32'd34, 3'd7, 32'd34, 1'b0);
    wait_done(2000);

    // Reset while WAITing on item 5 (number 4) of 0..20.
    run_scan(32'd0, 32'd20, 3'd7, 32'd13, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (go_i && number == 32'd4) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("reached_item5", 64'(seen), 64'd1);
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    exp_num_q.delete();
    exp_scan_q.delete();
    tick();
    reset = 1'b0;
    tick();

    // Clean full scan after reset.
    run_scan(32'd0, 32'd20, 3'd7, 32'd13, 1'b0);
    wait_done(1500);

`ifdef SCAN_WATCHDOG_EN
    // Analyzer never terminates: both items time out.
    stuck = 1'b1;
    run_scan(32'd4, 32'd5, 3'd0, 32'd0, 1'b1);
    wait_done(300);
    stuck = 1'b0;
`endif

    repeat (3) tick();
    check("scan_queue_empty", 64'(exp_scan_q.size()), 64'd0);
    check("item_queue_empty", 64'(exp_num_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
